// File: rtl/plot_scheduler_pkg.sv
// Shared widths, screen extents, plot record and scheduler state encoding
// for the plot scheduler slice.
package plot_scheduler_pkg;

   localparam int PLOT_X_W     = 8;
   localparam int PLOT_Y_W     = 7;
   localparam int PLOT_COLOR_W = 3;
   localparam int SCREEN_X_MAX = 159;
   localparam int SCREEN_Y_MAX = 119;

   // Default-width plot record; the scheduler rebuilds it with its own parameters.
   typedef struct packed {
      logic [PLOT_X_W-1:0]     x;
      logic [PLOT_Y_W-1:0]     y;
      logic [PLOT_COLOR_W-1:0] colour;
   } plot_t;

   typedef enum logic {
      DRAIN = 1'b0,
      CLEAR = 1'b1
   } sched_state_e;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO with registered read data and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module plot_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            wdata,
   input  logic                     pop,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            rdata  <= mem[rd_ptr];
         end
         if (do_push && !do_pop) count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/plot_scheduler.sv
// Paces a pixel source with a clock enable, queues its plots and feeds the VGA
// adapter one registered write per cycle, with a hardware screen-clear sweep.
module plot_scheduler
   import plot_scheduler_pkg::*;
#(
   parameter int DIV       = 2,
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 2,
   parameter int X_W       = PLOT_X_W,
   parameter int Y_W       = PLOT_Y_W,
   parameter int COLOR_W   = PLOT_COLOR_W,
   parameter int X_MAX     = SCREEN_X_MAX,
   parameter int Y_MAX     = SCREEN_Y_MAX
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   output logic               tick,
   input  logic [X_W-1:0]     src_x,
   input  logic [Y_W-1:0]     src_y,
   input  logic [COLOR_W-1:0] src_colour,
   input  logic               src_plot,
   output logic               pause,
   input  logic               clear_req,
   input  logic [COLOR_W-1:0] clear_colour,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [COLOR_W-1:0] vga_colour,
   output logic               vga_writeEn,
   output logic               busy,
   output logic               overflow
);

   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int DW    = X_W + Y_W + COLOR_W;

   localparam logic [CW-1:0]    DIV_LAST = CW'(DIV - 1);
   localparam logic [CNT_W-1:0] AF_THR   = CNT_W'(DEPTH - AF_MARGIN);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(X_MAX);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_MAX);

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] colour;
   } rec_t;

   sched_state_e        state, state_next;
   logic [CW-1:0]       div_cnt;
   logic                push_req, pop_req, sweep_write;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [DW-1:0]       fifo_rdata;
   rec_t                head;
   logic [X_W-1:0]      sweep_x, sw_x;
   logic [Y_W-1:0]      sweep_y, sw_y;
   logic [COLOR_W-1:0]  fill_colour, sw_colour;
   logic                sel_fifo;

   assign push_req = tick && src_plot;
   assign head     = fifo_rdata;

   plot_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk   (CLOCK_50),
      .rst_n (resetn),
      .push  (push_req),
      .wdata ({src_x, src_y, src_colour}),
      .pop   (pop_req),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick    <= (div_cnt == DIV_LAST);
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
      end
   end

   // A pending clear wins over draining, so nothing is popped in the transition cycle.
   always_comb begin
      state_next  = state;
      pop_req     = 1'b0;
      sweep_write = 1'b0;
      case (state)
         DRAIN: begin
            if (clear_req) state_next = CLEAR;
            else           pop_req    = !fifo_empty;
         end
         CLEAR: begin
            sweep_write = 1'b1;
            if (sweep_x == X_LAST && sweep_y == Y_LAST) state_next = DRAIN;
         end
         default: state_next = DRAIN;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state       <= DRAIN;
         sweep_x     <= '0;
         sweep_y     <= '0;
         fill_colour <= '0;
         sw_x        <= '0;
         sw_y        <= '0;
         sw_colour   <= '0;
         sel_fifo    <= 1'b0;
         vga_writeEn <= 1'b0;
         pause       <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state <= state_next;
         if (state == DRAIN && clear_req) begin
            sweep_x     <= '0;
            sweep_y     <= '0;
            fill_colour <= clear_colour;
         end else if (sweep_write) begin
            sw_x      <= sweep_x;
            sw_y      <= sweep_y;
            sw_colour <= fill_colour;
            if (sweep_x == X_LAST) begin
               sweep_x <= '0;
               sweep_y <= sweep_y + Y_W'(1);
            end else begin
               sweep_x <= sweep_x + X_W'(1);
            end
         end
         vga_writeEn <= pop_req || sweep_write;
         if (pop_req)          sel_fifo <= 1'b1;
         else if (sweep_write) sel_fifo <= 1'b0;
         pause    <= (fifo_count >= AF_THR) || (state == CLEAR) || clear_req;
         overflow <= overflow || (push_req && fifo_full && !pop_req);
      end
   end

   // Both write sources are registers that only change when they are written,
   // so the selected one holds the last address whenever the strobe is low.
   assign vga_x      = sel_fifo ? head.x      : sw_x;
   assign vga_y      = sel_fifo ? head.y      : sw_y;
   assign vga_colour = sel_fifo ? head.colour : sw_colour;

   assign busy = (state == CLEAR) || (fifo_count != '0) || vga_writeEn;

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Sits between a pixel source (html_parser or any plotting engine) and the VGA adapter in the top level.
- Generalises the fixed divide-by-2 clock plus gated writeEn into three things:
  - a parametrised clock-enable divider;
  - a plot-request FIFO with back-pressure to the source;
  - a hardware screen-clear sweep.
- The source runs on the divided enable. The VGA adapter receives at most one registered write per CLOCK_50 cycle.

Parameters:
- DIV, 2: CLOCK_50 cycles per source tick; must be ≥ 1.
- DEPTH, 8: FIFO entries; power of two, ≥ 4.
- AF_MARGIN, 2: pause asserts when occupancy ≥ DEPTH−AF_MARGIN.
- X_W, 8: x width.
- Y_W, 7: y width.
- COLOR_W, 3: colour width.
- X_MAX, 159: last column swept by clear.
- Y_MAX, 119: last row swept by clear.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  out  1  one-cycle clock enable for the source, every DIV cycles.
- src_x  in  X_W  plot x.
- src_y  in  Y_W  plot y.
- src_colour  in  COLOR_W  plot colour.
- src_plot  in  1  plot request, qualified by tick.
- pause  out  1  back-pressure to the source/reader.
- clear_req  in  1  start screen clear; level sampled every cycle.
- clear_colour  in  COLOR_W  fill colour, latched at clear start.
- vga_x  out  X_W  write address x.
- vga_y  out  Y_W  write address y.
- vga_colour  out  COLOR_W  write colour.
- vga_writeEn  out  1  write strobe, one pixel per high cycle.
- busy  out  1  clear in progress, or FIFO non-empty.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (asynchronous, resetn=0):
  - tick=0, pause=0, vga_*=0, vga_writeEn=0, busy=0, overflow=0.
  - Divider counter=0, FIFO empty, state=DRAIN.
- Divider:
  - Counter runs 0..DIV−1. tick=1 exactly when counter==DIV−1, registered.
  - DIV=1 gives tick=1 every cycle after reset.
  - First tick occurs in cycle DIV after reset release.
- Push:
  - Occurs when tick & src_plot & !full.
  - tick & src_plot & full: entry dropped, overflow set until reset.
  - src_plot with tick=0 is ignored.
- pause: registered, =1 when occupancy ≥ DEPTH−AF_MARGIN, or state==CLEAR, or a clear is pending.
- FSM states:
  - DRAIN:
    - FIFO non-empty → pop head; next cycle vga_* = head and vga_writeEn=1.
    - Push-to-strobe latency: 2 CLOCK_50 cycles when the FIFO was empty.
    - Push and pop in the same cycle are both performed, including when full; count is unchanged.
  - DRAIN → CLEAR:
    - Condition: clear_req=1 while in DRAIN.
    - Actions: latch clear_colour; set sweep x=0, y=0.
    - Pops stop from the transition cycle; a pop already in flight completes.
  - CLEAR:
    - One pixel per cycle: vga_writeEn=1, vga_x/vga_y = sweep counters, vga_colour = latched colour.
    - Order is x-major: x increments first; at X_MAX, x wraps to 0 and y increments.
    - At (X_MAX,Y_MAX), after that write → DRAIN.
    - Total (X_MAX+1)*(Y_MAX+1) strobes, contiguous.
    - Pushes accepted on tick are still queued. FIFO contents are drained after the clear, so plots issued during a clear land on top of it.
    - clear_req while in CLEAR is ignored (no restart).
- vga_writeEn: 0 on every cycle with no pop and no sweep write. vga_* hold their last value when vga_writeEn=0.
- busy = (state==CLEAR) | (occupancy≠0) | vga_writeEn.
- Widths: occupancy counter is log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Reset mid-clear or mid-drain: immediate return to reset values; FIFO contents discarded.

Decomposition:
- Shared package:
  - X_W/Y_W/COLOR_W defaults, replacing the X_BITES/Y_BITES/COLOR_BITES macros;
  - screen X_MAX/Y_MAX;
  - a packed plot record {x, y, colour};
  - state encoding {DRAIN, CLEAR}.
- Sub-module: plot_fifo.
  - Synchronous FIFO, parametrised DEPTH and data width.
  - Outputs full, empty, count.
  - Registered read data.

Test Plan:
- Reset/divider, DIV=2: release resetn → tick high on cycles 2, 4, 6…; all outputs 0 before the first tick.
- Single plot: src_plot=1 with (10,20,3) on one tick → exactly one vga_writeEn pulse with vga_x=10, vga_y=20, vga_colour=3, two cycles after the tick.
- Back-pressure, DEPTH=4, AF_MARGIN=2, writeEn sink stalled by forcing CLEAR:
  - pause rises after the 2nd queued push;
  - a 5th push on tick sets overflow=1;
  - exactly 4 writes emerge after the clear.
- Clear sweep, X_MAX=3, Y_MAX=2, clear_colour=5:
  - 12 consecutive strobes (0,0),(1,0)…(3,2), all colour 5;
  - pause=1 throughout;
  - busy falls after the last strobe.
- Plot during clear: push (7,7,1) mid-sweep → it appears one write after (X_MAX,Y_MAX); clear_req held high does not restart the sweep.
- Reset mid-clear: deassert resetn at sweep pixel 5 → vga_writeEn=0, pause=0, busy=0 immediately; FIFO empty after release.
